// File: rtl/dec2421_checker.sv
// dec2421_checker: decodes a stream of 2421 (Aiken) digits to BCD with one
// cycle of latency, flags illegal codes, checks the 0..9 counting sequence
// and tracks lock to the counting source.
// Build option: define DEC2421_ERRCNT_EN to implement the saturating error
// event counter; otherwise err_cnt is tied to zero.
module dec2421_checker #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERRW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      in_code,
  output logic            out_valid,
  output logic [3:0]      bcd,
  output logic            code_err,
  output logic            seq_err,
  output logic            locked,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t     state, state_nx;
  logic [3:0] ref_d, ref_nx;
  logic [3:0] good_cnt, good_nx;
  logic [3:0] dig;
  logic       legal;
  logic [3:0] succ;
  logic       is_succ;
  logic       code_err_nx, seq_err_nx;

  // Decode 2421 to BCD; illegal codes map to 4'hF.
  always_comb begin
    legal = 1'b1;
    dig   = 4'hF;
    case (in_code)
      4'b0000: dig = 4'd0;
      4'b0001: dig = 4'd1;
      4'b0010: dig = 4'd2;
      4'b0011: dig = 4'd3;
      4'b0100: dig = 4'd4;
      4'b1011: dig = 4'd5;
      4'b1100: dig = 4'd6;
      4'b1101: dig = 4'd7;
      4'b1110: dig = 4'd8;
      4'b1111: dig = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  assign succ    = (ref_d == 4'd9) ? 4'd0 : ref_d + 4'd1;
  assign is_succ = legal && (dig == succ);

  // Next-state, reference digit, run counter and error pulses.
  always_comb begin
    state_nx    = state;
    ref_nx      = ref_d;
    good_nx     = good_cnt;
    code_err_nx = 1'b0;
    seq_err_nx  = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        state_nx    = HUNT;
        good_nx     = '0;
        code_err_nx = 1'b1;
      end else begin
        ref_nx = dig;
        case (state)
          HUNT: begin
            state_nx = TRACK;
            good_nx  = '0;
          end
          TRACK: begin
            if (is_succ) begin
              good_nx = good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) state_nx = LOCKED;
            end else begin
              good_nx    = '0;
              seq_err_nx = 1'b1;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              state_nx   = TRACK;
              good_nx    = '0;
              seq_err_nx = 1'b1;
            end
          end
          default: begin
            state_nx = HUNT;
            good_nx  = '0;
          end
        endcase
      end
    end
  end

  // State register and tracking context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      ref_d    <= '0;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      ref_d    <= ref_nx;
      good_cnt <= good_nx;
    end
  end

  // Registered output stage; bcd holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bcd       <= '0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      code_err  <= code_err_nx;
      seq_err   <= seq_err_nx;
      if (in_valid) bcd <= dig;
    end
  end

  assign locked = (state == LOCKED);

`ifdef DEC2421_ERRCNT_EN
  logic [ERRW-1:0] err_q;

  // Saturating count of code/sequence error events.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if ((code_err_nx || seq_err_nx) && (err_q != '1)) begin
      err_q <= err_q + ERRW'(1);
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dec2421_checker.sv
// Self-checking bench for dec2421_checker: directed steps plus randomized
// traffic, compared against a run-length reference model.
module tb_dec2421_checker;

  localparam int unsigned LOCK_COUNT = 3;
  localparam int unsigned ERRW       = 2;
  localparam int          ERR_MAX    = (1 << ERRW) - 1;
`ifdef DEC2421_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [3:0]      in_code = '0;
  logic            out_valid;
  logic [3:0]      bcd;
  logic            code_err;
  logic            seq_err;
  logic            locked;
  logic [ERRW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_ov, m_ce, m_se, m_lock, have_ref;
  int m_bcd, m_err, refd, run;

  dec2421_checker #(.LOCK_COUNT(LOCK_COUNT), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .out_valid(out_valid), .bcd(bcd), .code_err(code_err),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [3:0] c);
    int tbl[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    for (int i = 0; i < 10; i++) if (tbl[i] == int'(c)) return i;
    return -1;
  endfunction

  function automatic logic [3:0] encode(input int d);
    int tbl[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    return tbl[d % 10][3:0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Locked means: a reference exists and at least LOCK_COUNT consecutive
  // correct successors have been seen since the last break.
  task automatic model(input bit r, input bit v, input logic [3:0] c);
    int d;
    if (r) begin
      m_ov = 0; m_ce = 0; m_se = 0; m_bcd = 0; m_err = 0;
      have_ref = 0; refd = 0; run = 0;
    end else if (!v) begin
      m_ov = 0; m_ce = 0; m_se = 0;
    end else begin
      d = decode(c);
      m_ov = 1; m_ce = 0; m_se = 0;
      if (d < 0) begin
        m_bcd = 15; m_ce = 1; have_ref = 0; run = 0;
      end else begin
        m_bcd = d;
        if (!have_ref) begin
          have_ref = 1; run = 0;
        end else if (d == (refd + 1) % 10) begin
          if (run < 15) run++;
        end else begin
          m_se = 1; run = 0;
        end
        refd = d;
      end
      if (ERR_EN && (m_ce || m_se) && m_err < ERR_MAX) m_err++;
    end
    m_lock = have_ref && (run >= int'(LOCK_COUNT));
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    @(negedge clk);
    rst = r; in_valid = v; in_code = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    chk("out_valid", {7'b0, out_valid}, {7'b0, m_ov});
    chk("bcd",       {4'b0, bcd},       8'(m_bcd));
    chk("code_err",  {7'b0, code_err},  {7'b0, m_ce});
    chk("seq_err",   {7'b0, seq_err},   {7'b0, m_se});
    chk("locked",    {7'b0, locked},    {7'b0, m_lock});
    chk("err_cnt",   8'(err_cnt),       8'(m_err));
  endtask

  initial begin
    logic [3:0] bad[6];
    int sel;
    bad = '{4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

    // reset for two cycles
    step(1, 0, 4'h0);
    step(1, 1, 4'h3);
    chk("rst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("rst_bcd", {4'b0, bcd}, 8'd0);
    chk("rst_locked", {7'b0, locked}, 8'd0);
    chk("rst_err_cnt", 8'(err_cnt), 8'd0);

    // clean count 0..9,0
    for (int i = 0; i <= 10; i++) begin
      step(0, 1, encode(i));
      chk("clean_bcd", {4'b0, bcd}, 8'(i % 10));
      chk("clean_locked", {7'b0, locked}, (i >= 3) ? 8'd1 : 8'd0);
    end
    chk("clean_err_cnt", 8'(err_cnt), 8'd0);

    // illegal code while locked, then re-entry without seq_err
    step(0, 1, 4'b0110);
    chk("ill_bcd", {4'b0, bcd}, 8'hF);
    chk("ill_code_err", {7'b0, code_err}, 8'd1);
    chk("ill_locked", {7'b0, locked}, 8'd0);
    chk("ill_err_cnt", 8'(err_cnt), ERR_EN ? 8'd1 : 8'd0);
    step(0, 1, 4'b0010);
    chk("reentry_seq_err", {7'b0, seq_err}, 8'd0);

    // lock again through 7, then break the sequence
    for (int i = 3; i <= 7; i++) step(0, 1, encode(i));
    chk("pre_break_locked", {7'b0, locked}, 8'd1);
    step(0, 1, 4'b0011);
    chk("brk_seq_err", {7'b0, seq_err}, 8'd1);
    chk("brk_bcd", {4'b0, bcd}, 8'd3);
    chk("brk_locked", {7'b0, locked}, 8'd0);
    step(0, 1, 4'b0100);
    step(0, 1, 4'b1011);
    chk("relock_2nd", {7'b0, locked}, 8'd0);
    step(0, 1, 4'b1100);
    chk("relock_3rd", {7'b0, locked}, 8'd1);

    // gaps and saturation
    step(1, 0, 4'h0);
    step(1, 0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, bad[i]);
      chk("sat_err_cnt", 8'(err_cnt), ERR_EN ? 8'((i < 3) ? i + 1 : 3) : 8'd0);
      step(0, 0, 4'hF);
      chk("gap_out_valid", {7'b0, out_valid}, 8'd0);
    end

    // reset mid-operation with a valid input present
    for (int i = 0; i < 4; i++) step(0, 1, encode(i));
    chk("mid_pre_locked", {7'b0, locked}, 8'd1);
    step(1, 1, 4'b1111);
    chk("mid_out_valid", {7'b0, out_valid}, 8'd0);
    chk("mid_locked", {7'b0, locked}, 8'd0);
    chk("mid_err_cnt", 8'(err_cnt), 8'd0);
    step(0, 1, 4'b0100);
    chk("mid_hunt_seq_err", {7'b0, seq_err}, 8'd0);
    chk("mid_hunt_bcd", {4'b0, bcd}, 8'd4);

    // randomized traffic biased toward correct successors
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 2)       step(1, 0, 4'h0);
      else if (sel < 15) step(0, 0, 4'($urandom));
      else if (sel < 70) step(0, 1, encode(refd + 1));
      else if (sel < 85) step(0, 1, encode(int'($urandom_range(0, 9))));
      else               step(0, 1, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec2421_checker.md
# dec2421_checker

Receive-side companion to the 2421 (Aiken) decade counter. Accepts a stream of 4-bit 2421 digits, decodes each to BCD with one cycle of latency, and flags codes that are not legal 2421. It also checks that successive digits follow the decade counting sequence 0→1→…→9→0, and tracks lock to the counting source. It sits downstream of any 2421 counter or link and feeds BCD display or monitoring logic.

## Interface
- LOCK_COUNT, 3: consecutive correct successors required to enter LOCKED (1..15).
- ERRW, 8: width of the error event counter.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_code is sampled on this edge when 1.
- in_code  input  4  2421 digit.
- out_valid  output  1  registered; 1 for exactly one cycle per accepted input.
- bcd  output  4  decoded BCD digit; 4'hF for an illegal code.
- code_err  output  1  registered; accepted code was illegal.
- seq_err  output  1  registered; legal code was not the expected successor.
- locked  output  1  state == LOCKED.
- err_cnt  output  ERRW  saturating count of code_err and seq_err events.

## Operation
- Legal 2421 map: 0000=0, 0001=1, 0010=2, 0011=3, 0100=4, 1011=5, 1100=6, 1101=7, 1110=8, 1111=9.
- Illegal codes: 0101, 0110, 0111, 1000, 1001, 1010.
- Internal state: ref digit (4b BCD), good_cnt (4b), FSM {HUNT, TRACK, LOCKED}.
- Expected successor of ref: ref+1, with 9 wrapping to 0.
- Transitions, evaluated only on in_valid=1:
  - Any state, illegal code → HUNT. Pulse code_err. good_cnt=0. ref is don't-care.
  - HUNT, legal code → TRACK. ref=digit, good_cnt=0. No seq_err, because there is no reference.
  - TRACK, correct successor → ref=digit, good_cnt+1. When good_cnt+1 == LOCK_COUNT, go to LOCKED.
  - TRACK, wrong legal digit → stay in TRACK. Pulse seq_err. ref=digit, good_cnt=0.
  - LOCKED, correct successor → stay in LOCKED. ref=digit.
  - LOCKED, wrong legal digit → TRACK. Pulse seq_err. ref=digit, good_cnt=0.
- A repeated digit (e.g. 3 then 3) is a wrong successor.
- code_err and seq_err are mutually exclusive. Each accepted input adds at most 1 to err_cnt.
- in_valid=0: state, ref, good_cnt and err_cnt hold. out_valid, code_err and seq_err are 0. bcd holds its last value.

## Timing
- Latency is 1 cycle. Input accepted at edge N: out_valid, bcd, code_err and seq_err are valid after edge N. locked reflects the new state after edge N.
- No backpressure. in_valid may be asserted every cycle.
- Reset values: out_valid=0, bcd=0, code_err=0, seq_err=0, locked=0, err_cnt=0, state=HUNT, ref=0, good_cnt=0.
- rst dominates in_valid. An input presented in the same cycle as rst is discarded and produces no output pulse.
- err_cnt saturates at all-ones and never wraps.

## Configuration
- DEC2421_ERRCNT_EN defined: err_cnt is implemented as described above.
- DEC2421_ERRCNT_EN undefined: the counter logic is omitted. err_cnt stays as a port and is tied to 0. All other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles. All outputs read 0 and locked=0.
- Clean count: stream 0000,0001,0010,0011,0100,1011,1100,1101,1110,1111,0000 back-to-back.
  - bcd reads 0..9,0 one cycle later.
  - locked rises after the 4th output.
  - No errors; err_cnt=0.
- Illegal code while locked: inject 0110 while LOCKED.
  - Next cycle: bcd=F, code_err=1, locked=0, err_cnt+1.
  - The following legal 0010 enters TRACK with no seq_err.
- Sequence break while locked: in LOCKED after digit 7 (1101), send 0011.
  - seq_err=1, bcd=3, locked=0.
  - Then 0100, 1011, 1100 relock on the 3rd output.
- Gaps and saturation: with ERRW=2, send 6 illegal codes separated by in_valid=0 cycles.
  - err_cnt reads 1,2,3,3,3,3.
  - out_valid is low during gaps.
  - With the macro undefined, err_cnt stays 0.
- Reset mid-operation: assert rst while LOCKED, with in_valid=1 and code 1111.
  - Next cycle: out_valid=0, locked=0, err_cnt=0.
  - The next digit is treated from HUNT.
